serializer: RTL

SERIALIZER -- requirements
Module: serializer

---
 rtl/serial_pkg.sv | 18 +
 rtl/serializer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Types and constants shared by the serializer and its matching
// deserializer.
//   state_e      : FSM state encoding (IDLE, SHIFT, WAIT_ACK)
//   SERIAL_WIDTH : default parallel word width in bits
// ---------------------------------------------------------------------------
package serial_pkg;

    localparam int SERIAL_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

endpackage

// File: rtl/serializer.sv
// ---------------------------------------------------------------------------
// serializer
// Parallel-to-serial converter with a bit-rate enable and a receiver
// acknowledge handshake. A word is loaded while idle, shifted out one bit
// per enabled cycle, and the block then waits for ack_in. If no ack arrives
// within ACK_TIMEOUT cycles, it raises a one-cycle error pulse and returns
// to idle.
//
// Parameters
//   WIDTH       : parallel word width in bits
//   MSB_FIRST   : 1 = MSB shifted out first, 0 = LSB first
//   ACK_TIMEOUT : cycles allowed in WAIT_ACK before abort
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   data_in       in   parallel word to transmit
//   load_in       in   load request, honoured only while status_out=1
//   status_out    out  1 = ready to accept a word
//   bit_en_in     in   bit-rate enable, one bit per enabled cycle
//   serial_out    out  serial data bit
//   write_out     out  one-cycle bit-valid strobe
//   ack_in        in   receiver acknowledge, honoured only in WAIT_ACK
//   word_done_out out  pulses together with the write of the last bit
//   error_out     out  one-cycle pulse on ack timeout
//
// State      | meaning
// -----------+--------------------------------------------------------
// IDLE       | ready, status_out=1, waiting for load_in
// SHIFT      | emitting one bit per bit_en_in cycle
// WAIT_ACK   | word sent, waiting for ack_in or for the timeout
// ---------------------------------------------------------------------------
module serializer
    import serial_pkg::*;
#(
    parameter int WIDTH       = SERIAL_WIDTH,
    parameter int MSB_FIRST   = 1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_in,
    output logic             status_out,
    input  logic             bit_en_in,
    output logic             serial_out,
    output logic             write_out,
    input  logic             ack_in,
    output logic             word_done_out,
    output logic             error_out
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(ACK_TIMEOUT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [TW-1:0]    tmo_inc;
    logic             status_q, status_d;
    logic             serial_q, serial_d;
    logic             write_q, write_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    assign tmo_inc = tmo_cnt_q + TW'(1);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        serial_d  = serial_q;
        write_d   = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_in) begin
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (bit_en_in) begin
                    write_d = 1'b1;
                    if (MSB_FIRST != 0) begin
                        serial_d = shift_q[WIDTH-1];
                        shift_d  = shift_q << 1;
                    end else begin
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                    // The counter holds at LAST_BIT instead of wrapping; it is
                    // cleared again by the next load.
                    if (bit_cnt_q == LAST_BIT) begin
                        done_d    = 1'b1;
                        tmo_cnt_d = '0;
                        state_d   = WAIT_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end

            WAIT_ACK: begin
                // ack takes priority, including on the timeout cycle itself.
                if (ack_in) begin
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        status_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            status_q  <= 1'b1;
            serial_q  <= 1'b0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            status_q  <= status_d;
            serial_q  <= serial_d;
            write_q   <= write_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign status_out    = status_q;
    assign serial_out    = serial_q;
    assign write_out     = write_q;
    assign word_done_out = done_q;
    assign error_out     = error_q;

endmodule
